// File: rtl/ilowx_mem_bridge.sv
// ilowx_mem_bridge
// ----------------
// Refill bridge sitting below the instruction cache. It takes one refill
// request at a time and builds the returned block out of single-beat reads
// on a narrow memory port. Cached requests read every beat of the aligned
// block in ascending address order. Uncached requests read one word, which
// lands in its natural lane of the block. All other lanes read as zero.
//
// Ports
//   clk_i, rst_i        clock and synchronous active-high reset
//   lx_req_*            refill request from the cache (valid/ready/addr/uncached)
//   lx_res_*            refill block back to the cache (valid/ready/blk)
//   mem_req_*           memory read request (valid/ready/addr)
//   mem_rsp_*           memory read data (valid/data, no backpressure)

module ilowx_mem_bridge #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int MEM_DW   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                lx_req_valid_i,
    output logic                lx_req_ready_o,
    input  logic [XLEN-1:0]     lx_req_addr_i,
    input  logic                lx_req_uncached_i,

    output logic                lx_res_valid_o,
    input  logic                lx_res_ready_i,
    output logic [BLK_SIZE-1:0] lx_res_blk_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,

    input  logic                mem_rsp_valid_i,
    input  logic [MEM_DW-1:0]   mem_rsp_data_i
);

    localparam int BEATS     = BLK_SIZE / MEM_DW;
    localparam int BLK_BYTES = BLK_SIZE / 8;
    localparam int OFF       = $clog2(BLK_BYTES);
    localparam int WOFF      = $clog2(MEM_DW / 8);
    localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [XLEN-1:0] BLK_MASK  = ~((XLEN'(1) << OFF) - XLEN'(1));
    localparam logic [XLEN-1:0] WORD_MASK = ~((XLEN'(1) << WOFF) - XLEN'(1));
    localparam logic [XLEN-1:0] LANE_MASK = XLEN'(BEATS - 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [CW-1:0]       beat_cnt;
    logic [CW-1:0]       unc_lane;
    logic                unc_q;
    logic [XLEN-1:0]     base_addr;
    logic [BLK_SIZE-1:0] data_buf;
    logic [CW-1:0]       wr_lane;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. An uncached fetch is a single beat, so its first
    // response finishes the block just as the last cached beat does.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (lx_req_valid_i)  state_nxt = REQ;
            REQ:  if (mem_req_ready_i) state_nxt = WAIT;
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (unc_q || (beat_cnt == LAST_BEAT)) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            RESP: if (lx_res_ready_i)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. The memory address is driven only while a read is
    // offered. This keeps the port at zero whenever no request is pending.
    always_comb begin
        lx_req_ready_o  = (state == IDLE);
        mem_req_valid_o = (state == REQ);
        lx_res_valid_o  = (state == RESP);
        lx_res_blk_o    = data_buf;
        mem_req_addr_o  = '0;
        if (state == REQ) begin
            mem_req_addr_o = base_addr + (XLEN'(beat_cnt) << WOFF);
        end
    end

    // Cached beats fill lanes in order. The single uncached word goes into
    // the lane selected by its address within the block.
    assign wr_lane = unc_q ? unc_lane : beat_cnt;

    // Request capture and block assembly. Request inputs are looked at only
    // in the IDLE handshake cycle. Memory data is taken only in WAIT, so a
    // stray or late response in any other state is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt  <= '0;
            unc_lane  <= '0;
            unc_q     <= 1'b0;
            base_addr <= '0;
            data_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lx_req_valid_i) begin
                        unc_q    <= lx_req_uncached_i;
                        beat_cnt <= '0;
                        data_buf <= '0;
                        unc_lane <= CW'((lx_req_addr_i >> WOFF) & LANE_MASK);
                        if (lx_req_uncached_i) begin
                            base_addr <= lx_req_addr_i & WORD_MASK;
                        end else begin
                            base_addr <= lx_req_addr_i & BLK_MASK;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        data_buf[wr_lane*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
                        if (!unc_q && (beat_cnt != LAST_BEAT)) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ilowx_mem_bridge.md
Name: ilowx_mem_bridge

Overview:
Miss-path stage directly downstream of the instruction cache. It consumes the cache's lower-level refill request (valid/ready/addr/uncached, XLEN address) and returns a BLK_SIZE-bit block (valid/ready/blk). It fetches the block from a narrow MEM_DW-bit memory port as sequential single-beat reads. Cached requests fetch a full aligned block; uncached requests fetch a single word.

Parameters:
XLEN, 32, address width
BLK_SIZE, 128, refill block width in bits
MEM_DW, 32, memory data width; BLK_SIZE must be an integer multiple of it
(derived) BEATS = BLK_SIZE/MEM_DW = 4; BLK_BYTES = BLK_SIZE/8 = 16; OFF = log2(BLK_BYTES) = 4

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
lx_req_valid_i  in  1  refill request valid
lx_req_ready_o  out  1  bridge can accept a request
lx_req_addr_i  in  XLEN  request byte address
lx_req_uncached_i  in  1  1 = single-word uncached fetch
lx_res_valid_o  out  1  refill block valid
lx_res_ready_i  in  1  cache accepts block
lx_res_blk_o  out  BLK_SIZE  refill block
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  XLEN  memory read byte address, MEM_DW-aligned
mem_rsp_valid_i  in  1  memory read data valid (no backpressure)
mem_rsp_data_i  in  MEM_DW  memory read data

Behaviour:
- Clock is clk_i. Reset is rst_i, synchronous and active-high.
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset values: state IDLE, beat counter 0, data buffer 0, lx_res_valid_o 0, mem_req_valid_o 0, mem_req_addr_o 0. lx_req_ready_o is 1 out of reset because it is high exactly in IDLE.
- IDLE:
  - lx_req_ready_o=1.
  - On lx_req_valid_i, latch uncached flag; clear buffer; beat counter=0; go to REQ.
  - Base address latched: cached = addr with low OFF bits zeroed; uncached = addr with low log2(MEM_DW/8) bits zeroed.
- REQ:
  - mem_req_valid_o=1, mem_req_addr_o = base + counter*(MEM_DW/8).
  - Valid and address hold stable until mem_req_ready_i; on handshake go to WAIT.
- WAIT:
  - mem_req_valid_o=0. Waits for mem_rsp_valid_i. Earliest response is the cycle after the REQ handshake.
  - Cached: data written to buffer lane [counter*MEM_DW +: MEM_DW]. If counter==BEATS-1 go to RESP, else counter++ and return to REQ.
  - Uncached: data written to lane addr[OFF-1:log2(MEM_DW/8)], other lanes stay 0; go to RESP.
- RESP:
  - lx_res_valid_o=1, lx_res_blk_o=buffer, both stable until lx_res_ready_i.
  - On handshake go to IDLE; lx_res_valid_o=0 the next cycle.
  - A new request can be accepted the cycle after the response handshake; there is no request/response overlap.
- lx_res_blk_o equals the buffer in all states.
- At most one memory read is outstanding. mem_rsp_valid_i is ignored outside WAIT.
- Latency, with mem ready always high and the response one cycle after acceptance:
  - Cached: request accept at cycle 0; lx_res_valid_o rises at cycle 1+2*BEATS = 9.
  - Uncached: lx_res_valid_o rises at cycle 3.
- Address arithmetic is modulo 2^XLEN; a block at the top of the address space does not cross alignment because the base is block-aligned.
- Reset asserted in any state: next cycle is in reset state; an in-flight memory response arriving afterwards is dropped.
- lx_req_* inputs are sampled only in the IDLE handshake cycle; changes afterwards have no effect.

Test Plan:
- Cached fetch, addr=0x0000_1234, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem addrs 0x1230, 0x1234, 0x1238, 0x123C in order; blk=0x44444444_33333333_22222222_11111111; lx_res_valid_o at cycle 9.
- Uncached fetch, addr=0x0000_2008, data 0xDEADBEEF -> single mem read at 0x2008; blk=0x00000000_DEADBEEF_00000000_00000000; lx_res_valid_o at cycle 3.
- Backpressure: mem_req_ready_i low 3 cycles on beat 2, and lx_res_ready_i low 5 cycles -> mem addr/valid stable while stalled; lx_res_blk_o/valid stable; lx_req_ready_o stays 0 throughout.
- Spurious mem_rsp_valid_i=1 with data 0xBAD in IDLE and REQ -> buffer unchanged; final blk matches only WAIT-phase data.
- rst_i pulsed in WAIT of beat 1, then the memory response arrives -> next cycle all outputs at reset values, lx_req_ready_o=1; response ignored; a subsequent cached request at 0x40 completes correctly.
- Top-of-memory cached fetch, addr=0xFFFF_FFF4 -> addrs 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC; no wrap to 0.
